instr_mem_sync: RTL
===================

# instr_mem_sync

Parametrised, synchronous-read instruction memory with a runtime programming port and a post-reset clear sequencer. It replaces the fixed 32-word combinational instruction store in front of the fetch stage. It takes a byte-addressed PC and returns the addressed word one cycle later with a valid strobe. It flags misaligned or out-of-range fetches, and lets a loader write program words at runtime instead of relying on hard-coded contents.

## Interface
Parameters:
- DATA_W, 32, instruction word width in bits
- DEPTH, 32, number of words; power of two, ≥2
- PC_W, 32, width of the byte-address PC input
- NOP_WORD, 32'h00000000, fill value after reset; returned on faulting fetches

ADDR_W = $clog2(DEPTH) is derived and is not a parameter.

Ports:
- clk, in, 1, single clock; all logic is on its rising edge
- rst, in, 1, synchronous active-high reset
- fetch_req, in, 1, fetch request for pc this cycle
- pc, in, PC_W, byte address of the instruction
- instr, out, DATA_W, fetched word
- instr_valid, out, 1, one-cycle strobe: instr/fault are valid for the prior request
- fault, out, 1, prior request was misaligned or out of range
- ready, out, 1, memory is initialised; fetches and writes are accepted
- prog_we, in, 1, program-word write enable
- prog_addr, in, ADDR_W, word address for the write
- prog_data, in, DATA_W, word to write

## Operation
- **FSM states:**
  - INIT: the clear pointer walks 0..DEPTH-1 and writes NOP_WORD, one word per cycle. ready=0.
  - RUN: ready=1.
- **Transitions:**
  - rst forces INIT with pointer=0 from any state.
  - INIT→RUN on the cycle the pointer writes DEPTH-1.
  - RUN persists until rst.
- **Word index:** pc[ADDR_W+1:2].
- **Misaligned:** pc[1:0]≠0.
- **Out of range:** any of pc[PC_W-1:ADDR_W+2] is nonzero.
- **Fetch accepted:** when fetch_req & ready.
  - Next cycle: instr_valid=1.
  - Clean fetch: instr=mem[index], fault=0.
  - Misaligned or out-of-range fetch: instr=NOP_WORD, fault=1.
- **No accepted fetch:**
  - instr_valid=0 and fault=0.
  - instr holds its last value.
- **Fetch while ready=0:** ignored. No strobe is produced and nothing is queued.
- **Program write:** accepted when prog_we & ready; mem[prog_addr]←prog_data at the edge. prog_we during INIT is dropped silently.
- **Same-cycle write and fetch, same word:** write-first. The fetch returns prog_data.
- **Back-to-back fetches:** one result per cycle, full throughput.
- **Reset mid-operation:**
  - A pending result is discarded: instr_valid=0 on the cycle after rst.
  - Memory contents are re-cleared.

## Timing
- **Reset values:** instr=NOP_WORD, instr_valid=0, fault=0, ready=0.
- **Clear sequence:** the first edge with rst=0 clears word 0. ready rises after DEPTH such edges, i.e. it is 1 in the cycle following the edge that clears word DEPTH-1.
- **Read latency:** exactly 1 cycle from request edge to instr_valid.
- **Fetch path:** no combinational path from pc/fetch_req to any output; all outputs are registered.
- **Write visibility:** a write at edge N is visible to a fetch issued in the cycle before edge N (bypass) and all later fetches.

## Structure
- **Package instr_mem_pkg:**
  - state enum {INIT, RUN}
  - default DATA_W and NOP_WORD constants
  - function fetch_fault(pc) returning the misaligned/out-of-range flag
- **Sub-module ram_1r1w:** parametrised DATA_W×DEPTH, one synchronous read port, one write port, no reset on the array. It is the natural and only sub-module.
- **Write-port mux:** the top-level write port is driven by the clear pointer in INIT and by the prog_* signals in RUN.
- **Top level also holds:** the FSM, the fault logic, the write-first bypass compare, and the output registers.

## Test plan
- **Reset and clear:** release rst with DEPTH=32 → ready=0 for 32 cycles, then 1. A fetch of every word 0x00..0x7C returns 0x00000000 with fault=0.
- **Program and readback:** write prog_addr=2 with 0x2067fff7, then fetch pc=0x08 → one cycle later instr=0x2067fff7, instr_valid=1, fault=0.
- **Faults:**
  - pc=0x06 → instr=NOP_WORD, fault=1.
  - pc=0x80 with DEPTH=32 → fault=1.
  - Both cases: memory is unchanged.
- **Write-first bypass:** word 5 holds 0x00a42820. In the same cycle, write 0x00642824 to word 5 and fetch pc=0x14 → instr=0x00642824.
- **Reset mid-stream:**
  - Streaming fetches are interrupted by a 1-cycle rst → instr_valid=0 on the next cycle and ready=0 for 32 cycles.
  - A prog_we during INIT is dropped, so the previously programmed word reads NOP_WORD afterwards.
- **Parametrisation:** with DEPTH=64, DATA_W=16, issue back-to-back fetches → a result every cycle, and pc=0x100 flags fault.

Source files
------------

// File: rtl/instr_mem_sync_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// Holds the sequencer states, default constants and the fetch fault check.
package instr_mem_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int          DEF_DATA_W   = 32;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
  localparam int          MAX_PC_W     = 64;

  function automatic logic fetch_fault(
    input logic [MAX_PC_W-1:0] pc,
    input int                  addr_w,
    input int                  pc_w
  );
    logic f;
    f = |pc[1:0];
    for (int i = 0; i < MAX_PC_W; i++) begin
      if (i >= addr_w + 2 && i < pc_w && pc[i]) begin
        f = 1'b1;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/instr_mem_sync_ram_1r1w.sv
// Word array with one registered read port and one write port.
// Read returns the pre-write contents on a same-address collision.
module ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction store with runtime programming port.
// Clears itself to NOP_WORD after reset before accepting traffic.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [PC_W-1:0]          pc,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  output logic                     fault,
  output logic                     ready,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] idx;
  logic              acc;
  logic              flt;
  logic              hit;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              sel_nop;
  logic              sel_byp;
  logic [DATA_W-1:0] byp_q;

  assign idx = pc[ADDR_W+1:2];
  assign acc = fetch_req & ready;
  assign flt = fetch_fault(MAX_PC_W'(pc), ADDR_W, PC_W);
  assign hit = prog_we & (prog_addr == idx);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = prog_addr;
    ram_wdata = prog_data;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = NOP_WORD;
    end else begin
      ram_we    = prog_we;
    end
  end

  ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .re     (acc),
    .raddr  (idx),
    .rdata  (ram_rdata),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else if (state == INIT) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == LAST) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Selectors only move on an accepted fetch so instr holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      sel_nop     <= 1'b1;
      sel_byp     <= 1'b0;
      byp_q       <= NOP_WORD;
    end else begin
      instr_valid <= acc;
      fault       <= acc & flt;
      if (acc) begin
        sel_nop <= flt;
        sel_byp <= ~flt & hit;
        byp_q   <= prog_data;
      end
    end
  end

  always_comb begin
    unique case (1'b1)
      sel_nop: instr = NOP_WORD;
      sel_byp: instr = byp_q;
      default: instr = ram_rdata;
    endcase
  end

endmodule
